// File: rtl/peripheral_bus_pkg.sv
// rtl/peripheral_bus_pkg.sv - shared types and constants for the peripheral bus hub
package peripheral_bus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, HUB, RESPOND} hub_state_t;

    localparam logic [7:0] REG_PENDING    = 8'h00;
    localparam logic [7:0] REG_ENABLE     = 8'h04;
    localparam logic [7:0] REG_ERR_STATUS = 8'h08;
    localparam logic [7:0] REG_TIMEOUT    = 8'h0C;

    localparam int ERR_TIMEOUT_BIT  = 0;
    localparam int ERR_UNMAPPED_BIT = 1;
    localparam int ERR_MULTI_BIT    = 2;

    localparam logic [31:0] PB_UNMAPPED_DATA = 32'hFFFF_FFFF;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/peripheral_irq_ctrl.sv
// rtl/peripheral_irq_ctrl.sv - per-source pending/enable interrupt controller with edge/level mode
module peripheral_irq_ctrl #(
    parameter int                   IRQ_COUNT     = 10,
    parameter logic [IRQ_COUNT-1:0] IRQ_EDGE_MASK = '1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_COUNT-1:0] irq_src,
    input  logic                 clear_we,
    input  logic [IRQ_COUNT-1:0] clear_mask,
    input  logic                 enable_we,
    input  logic [IRQ_COUNT-1:0] enable_data,
    output logic [IRQ_COUNT-1:0] pending,
    output logic [IRQ_COUNT-1:0] enable,
    output logic [IRQ_COUNT-1:0] irq_o,
    output logic                 irq_any
);

    logic [IRQ_COUNT-1:0] src_q;
    logic [IRQ_COUNT-1:0] src_q2;
    logic [IRQ_COUNT-1:0] set_vec;
    logic [IRQ_COUNT-1:0] pending_next;
    logic [IRQ_COUNT-1:0] enable_next;

    // Set is OR-ed in after the clear so a same-cycle source event is never lost.
    always_comb begin
        set_vec      = (IRQ_EDGE_MASK & src_q & ~src_q2) | (~IRQ_EDGE_MASK & src_q);
        pending_next = (pending & ~(clear_we ? clear_mask : '0)) | set_vec;
        enable_next  = enable_we ? enable_data : enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            src_q2  <= '0;
            pending <= '0;
            enable  <= '0;
            irq_o   <= '0;
            irq_any <= 1'b0;
        end else begin
            src_q   <= irq_src;
            src_q2  <= src_q;
            pending <= pending_next;
            enable  <= enable_next;
            irq_o   <= pending_next & enable_next;
            irq_any <= |(pending_next & enable_next);
        end
    end

endmodule

// File: rtl/peripheral_bus_hub.sv
// rtl/peripheral_bus_hub.sv - Wishbone to shared peripheral bus bridge with watchdog and interrupt controller
module peripheral_bus_hub
    import peripheral_bus_pkg::*;
#(
    parameter int                   NUM_PERIPHERALS = 4,
    parameter int                   IRQ_COUNT       = 10,
    parameter logic [IRQ_COUNT-1:0] IRQ_EDGE_MASK   = '1,
    parameter logic [7:0]           HUB_ID          = 8'hFF,
    parameter logic [15:0]          TIMEOUT_DEFAULT = 16'd255,
    parameter bit                   ERR_ON_UNMAPPED = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    input  logic                          wb_we_i,
    input  logic [3:0]                    wb_sel_i,
    input  logic [23:0]                   wb_adr_i,
    input  logic [31:0]                   wb_data_i,
    output logic                          wb_ack_o,
    output logic                          wb_stall_o,
    output logic                          wb_error_o,
    output logic [31:0]                   wb_data_o,
    output logic                          pb_we,
    output logic                          pb_oe,
    output logic [23:0]                   pb_address,
    output logic [3:0]                    pb_byteSelect,
    output logic [31:0]                   pb_dataWrite,
    input  logic [NUM_PERIPHERALS-1:0]    pb_busy,
    input  logic [NUM_PERIPHERALS-1:0]    pb_requestOutput,
    input  logic [32*NUM_PERIPHERALS-1:0] pb_dataRead,
    input  logic [IRQ_COUNT-1:0]          irq_src,
    output logic [IRQ_COUNT-1:0]          irq_o,
    output logic                          irq_any
);

    hub_state_t           state;
    logic                 we_q;
    logic [15:0]          wait_cnt;
    logic [15:0]          timeout_reg;
    logic [15:0]          timeout_next;
    logic [31:0]          err_status;
    logic [31:0]          rd_mux;
    logic [31:0]          hub_rdata;
    logic [31:0]          sel_mask;
    logic                 claim_any;
    logic                 claim_multi;
    logic                 hub_wr;
    logic [IRQ_COUNT-1:0] pending;
    logic [IRQ_COUNT-1:0] enable;

    assign wb_stall_o  = (state != IDLE);
    assign claim_any   = |pb_requestOutput;
    assign claim_multi = |(pb_requestOutput & (pb_requestOutput - NUM_PERIPHERALS'(1)));
    assign hub_wr      = (state == HUB) && we_q;
    assign sel_mask    = {{8{pb_byteSelect[3]}}, {8{pb_byteSelect[2]}},
                          {8{pb_byteSelect[1]}}, {8{pb_byteSelect[0]}}};
    assign timeout_next = {pb_byteSelect[1] ? pb_dataWrite[15:8] : timeout_reg[15:8],
                           pb_byteSelect[0] ? pb_dataWrite[7:0]  : timeout_reg[7:0]};

    // Scan from the top so the lowest-index claimant overwrites the others.
    always_comb begin
        rd_mux = PB_UNMAPPED_DATA;
        for (int i = NUM_PERIPHERALS - 1; i >= 0; i--) begin
            if (pb_requestOutput[i]) rd_mux = pb_dataRead[32*i +: 32];
        end
    end

    always_comb begin
        hub_rdata = '0;
        case (pb_address[7:0])
            REG_PENDING:    hub_rdata = 32'(pending);
            REG_ENABLE:     hub_rdata = 32'(enable);
            REG_ERR_STATUS: hub_rdata = err_status;
            REG_TIMEOUT:    hub_rdata = {16'h0000, timeout_reg};
            default:        hub_rdata = '0;
        endcase
    end

    peripheral_irq_ctrl #(
        .IRQ_COUNT    (IRQ_COUNT),
        .IRQ_EDGE_MASK(IRQ_EDGE_MASK)
    ) u_irq_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .clear_we   (hub_wr && (pb_address[7:0] == REG_PENDING)),
        .clear_mask (IRQ_COUNT'(pb_dataWrite & sel_mask)),
        .enable_we  (hub_wr && (pb_address[7:0] == REG_ENABLE)),
        .enable_data(IRQ_COUNT'(byte_merge(32'(enable), pb_dataWrite, pb_byteSelect))),
        .pending    (pending),
        .enable     (enable),
        .irq_o      (irq_o),
        .irq_any    (irq_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            wait_cnt      <= '0;
            timeout_reg   <= TIMEOUT_DEFAULT;
            err_status    <= '0;
            wb_ack_o      <= 1'b0;
            wb_error_o    <= 1'b0;
            wb_data_o     <= '0;
            pb_we         <= 1'b0;
            pb_oe         <= 1'b0;
            pb_address    <= '0;
            pb_byteSelect <= '0;
            pb_dataWrite  <= '0;
        end else begin
            wb_ack_o   <= 1'b0;
            wb_error_o <= 1'b0;
            wb_data_o  <= '0;
            case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        we_q          <= wb_we_i;
                        pb_address    <= wb_adr_i;
                        pb_byteSelect <= wb_sel_i;
                        pb_dataWrite  <= wb_data_i;
                        wait_cnt      <= '0;
                        if (wb_adr_i[23:16] == HUB_ID) begin
                            state <= HUB;
                        end else begin
                            state <= ACCESS;
                            pb_we <= wb_we_i;
                            pb_oe <= !wb_we_i;
                        end
                    end
                end
                ACCESS: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                        pb_we <= 1'b0;
                        pb_oe <= 1'b0;
                    end else if (!(|pb_busy)) begin
                        state <= RESPOND;
                        pb_we <= 1'b0;
                        pb_oe <= 1'b0;
                        if (!claim_any) begin
                            err_status[ERR_UNMAPPED_BIT] <= 1'b1;
                            err_status[31:8]             <= pb_address;
                            if (ERR_ON_UNMAPPED) begin
                                wb_error_o <= 1'b1;
                            end else begin
                                wb_ack_o  <= 1'b1;
                                wb_data_o <= we_q ? 32'h0 : PB_UNMAPPED_DATA;
                            end
                        end else begin
                            if (claim_multi) begin
                                err_status[ERR_MULTI_BIT] <= 1'b1;
                                err_status[31:8]          <= pb_address;
                            end
                            wb_ack_o  <= 1'b1;
                            wb_data_o <= we_q ? 32'h0 : rd_mux;
                        end
                    end else if ((timeout_reg != 16'h0) && (wait_cnt == timeout_reg)) begin
                        state                       <= RESPOND;
                        pb_we                       <= 1'b0;
                        pb_oe                       <= 1'b0;
                        wb_error_o                  <= 1'b1;
                        err_status[ERR_TIMEOUT_BIT] <= 1'b1;
                        err_status[31:8]            <= pb_address;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                HUB: begin
                    state    <= RESPOND;
                    wb_ack_o <= 1'b1;
                    if (we_q) begin
                        if (pb_address[7:0] == REG_ERR_STATUS) err_status  <= '0;
                        if (pb_address[7:0] == REG_TIMEOUT)    timeout_reg <= timeout_next;
                    end else begin
                        wb_data_o <= hub_rdata;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bus_hub.sv
// tb/tb_peripheral_bus_hub.sv - scoreboard testbench for peripheral_bus_hub
module tb_peripheral_bus_hub;

    localparam int NP  = 4;
    localparam int IRQ = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]      wb_sel = 4'h0;
    logic [23:0]     wb_adr = '0;
    logic [31:0]     wb_dat = '0;
    logic            wb_ack_o, wb_stall_o, wb_error_o;
    logic [31:0]     wb_data_o;
    logic            pb_we, pb_oe;
    logic [23:0]     pb_address;
    logic [3:0]      pb_byteSelect;
    logic [31:0]     pb_dataWrite;
    logic [NP-1:0]   pb_busy = '0;
    logic [NP-1:0]   pb_request = '0;
    logic [31:0]     per_data [NP];
    logic [32*NP-1:0] pb_dataRead;
    logic [IRQ-1:0]  irq_src = '0;
    logic [IRQ-1:0]  irq_o;
    logic            irq_any;

    typedef struct {
        logic        err;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          resp_cnt = 0;
    int          we_cycles = 0;
    logic [31:0] exp_wdata = '0;
    int          lat, stalls;

    assign pb_dataRead = {per_data[3], per_data[2], per_data[1], per_data[0]};

    always #5 clk = ~clk;

    peripheral_bus_hub #(
        .NUM_PERIPHERALS(NP),
        .IRQ_COUNT      (IRQ),
        .IRQ_EDGE_MASK  (10'h1FF),
        .HUB_ID         (8'hFF),
        .TIMEOUT_DEFAULT(16'd255),
        .ERR_ON_UNMAPPED(1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_cyc_i        (wb_cyc),
        .wb_stb_i        (wb_stb),
        .wb_we_i         (wb_we),
        .wb_sel_i        (wb_sel),
        .wb_adr_i        (wb_adr),
        .wb_data_i       (wb_dat),
        .wb_ack_o        (wb_ack_o),
        .wb_stall_o      (wb_stall_o),
        .wb_error_o      (wb_error_o),
        .wb_data_o       (wb_data_o),
        .pb_we           (pb_we),
        .pb_oe           (pb_oe),
        .pb_address      (pb_address),
        .pb_byteSelect   (pb_byteSelect),
        .pb_dataWrite    (pb_dataWrite),
        .pb_busy         (pb_busy),
        .pb_requestOutput(pb_request),
        .pb_dataRead     (pb_dataRead),
        .irq_src         (irq_src),
        .irq_o           (irq_o),
        .irq_any         (irq_any)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pb_we) begin
            we_cycles++;
            check("pb_dataWrite_stable", pb_dataWrite, exp_wdata);
        end
        if (wb_ack_o || wb_error_o) begin
            resp_cnt++;
            check("ack_err_exclusive", wb_ack_o & wb_error_o, 0);
            if (sb.size() == 0) begin
                check("unexpected_response", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_err"}, wb_error_o, mon_e.err);
                check({mon_e.tag, "_data"}, wb_data_o, mon_e.data);
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [23:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_data,
                           input string tag, input bit irq0_pulse,
                           output int lat_o, output int stalls_o);
        exp_t e;
        e.err = exp_err; e.data = exp_data; e.tag = tag;
        sb.push_back(e);
        exp_wdata = dat;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
        if (irq0_pulse) irq_src[0] = 1'b1;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        if (irq0_pulse) irq_src[0] = 1'b0;
        lat_o = 0; stalls_o = 0;
        while (lat_o < 300) begin
            if (wb_stall_o) stalls_o++;
            if (wb_ack_o || wb_error_o) break;
            @(posedge clk); #1;
            lat_o++;
        end
        if (lat_o >= 300) check({tag, "_resp_bound"}, 0, 1);
        @(posedge clk); #1;
        wb_cyc = 1'b0;
        check({tag, "_single_resp"}, wb_ack_o | wb_error_o, 0);
        check({tag, "_idle_after"}, wb_stall_o, 0);
    endtask

    task automatic rd(input logic [23:0] adr, input logic exp_err, input logic [31:0] exp_data, input string tag);
        int l, s;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, exp_err, exp_data, tag, 1'b0, l, s);
    endtask

    task automatic wr(input logic [23:0] adr, input logic [31:0] dat, input string tag);
        int l, s;
        wb_xfer(1'b1, adr, dat, 4'hF, 1'b0, 32'h0, tag, 1'b0, l, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r0;
        for (int i = 0; i < NP; i++) per_data[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", wb_ack_o, 0);
        check("rst_stall", wb_stall_o, 0);
        check("rst_pb_strobes", {pb_we, pb_oe}, 0);
        check("rst_irq", {irq_any, irq_o}, 0);
        rst_n = 1'b1;

        rd(24'hFF000C, 1'b0, 32'h0000_00FF, "rst_timeout");
        rd(24'hFF0004, 1'b0, 32'h0, "rst_enable");
        rd(24'hFF0010, 1'b0, 32'h0, "hub_unused_offset");

        // single read from peripheral 2
        pb_request = 4'b0100; per_data[2] = 32'hA5A5_0003;
        wb_xfer(1'b0, 24'h000200, 32'h0, 4'hF, 1'b0, 32'hA5A5_0003, "single_read", 1'b0, lat, stalls);
        check("single_read_latency", lat + 1, 2);
        check("single_read_stalls", stalls, 2);

        // write with peripheral 1 busy for 5 cycles
        pb_request = 4'b0010; pb_busy = 4'b0010; we_cycles = 0;
        fork
            begin
                wait (pb_we);
                repeat (5) @(posedge clk);
                #1 pb_busy[1] = 1'b0;
            end
        join_none
        wb_xfer(1'b1, 24'h000104, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, "busy_write", 1'b0, lat, stalls);
        check("busy_write_we_cycles", we_cycles, 6);
        check("busy_write_latency", lat, 6);

        // byte-select write of TIMEOUT low byte only, then timeout
        wb_xfer(1'b1, 24'hFF000C, 32'hAAAA_AA0A, 4'b0001, 1'b0, 32'h0, "timeout_wr", 1'b0, lat, stalls);
        rd(24'hFF000C, 1'b0, 32'h0000_000A, "timeout_rd");
        pb_request = 4'b0001; pb_busy = 4'b0001;
        wb_xfer(1'b0, 24'h001234, 32'h0, 4'hF, 1'b1, 32'h0, "timeout_access", 1'b0, lat, stalls);
        check("timeout_latency", lat, 11);
        pb_busy = '0;
        rd(24'hFF0008, 1'b0, 32'h0012_3401, "timeout_status");
        wr(24'hFF0008, 32'h0, "status_clear1");
        rd(24'hFF0008, 1'b0, 32'h0, "status_cleared");

        // unmapped read
        pb_request = '0;
        rd(24'h000040, 1'b1, 32'h0, "unmapped_read");
        rd(24'hFF0008, 1'b0, 32'h0000_4002, "unmapped_status");
        wr(24'hFF0008, 32'hFFFF_FFFF, "status_clear2");

        // multi-hit: peripherals 0 and 3
        pb_request = 4'b1001; per_data[0] = 32'h1111_0000; per_data[3] = 32'h3333_0003;
        rd(24'h000300, 1'b0, 32'h1111_0000, "multi_read");
        rd(24'hFF0008, 1'b0, 32'h0003_0004, "multi_status");
        wr(24'hFF0008, 32'h0, "status_clear3");

        // interrupts: bit 0 edge, bit 9 level
        wr(24'hFF0004, 32'h0000_03FF, "irq_enable_wr");
        rd(24'hFF0004, 1'b0, 32'h0000_03FF, "irq_enable_rd");
        @(posedge clk); #1;
        irq_src[9] = 1'b1; irq_src[0] = 1'b1;
        @(posedge clk); #1;
        irq_src[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("irq_set", irq_o, 10'h201);
        check("irq_any_set", irq_any, 1);
        rd(24'hFF0000, 1'b0, 32'h0000_0201, "pending_rd1");
        wr(24'hFF0000, 32'h0000_0201, "pending_w1c");
        repeat (3) @(posedge clk);
        #1;
        check("irq_after_w1c", irq_o, 10'h200);
        rd(24'hFF0000, 1'b0, 32'h0000_0200, "pending_rd2");
        wb_xfer(1'b1, 24'hFF0000, 32'h0000_0001, 4'hF, 1'b0, 32'h0, "w1c_vs_edge", 1'b1, lat, stalls);
        repeat (3) @(posedge clk);
        #1;
        check("irq_set_wins", irq_o, 10'h201);

        // abort by dropping cyc during ACCESS
        pb_request = 4'b0001; pb_busy = 4'b0001; r0 = resp_cnt;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 24'h000010; wb_sel = 4'hF;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        check("abort_in_access", wb_stall_o & pb_oe, 1);
        @(posedge clk); #1;
        wb_cyc = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", {wb_stall_o, pb_oe}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_resp", resp_cnt - r0, 0);

        // reset mid-access
        r0 = resp_cnt;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 24'h000020;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", wb_stall_o, 0);
        check("midrst_pb", {pb_we, pb_oe, pb_address, pb_byteSelect, pb_dataWrite}, 0);
        check("midrst_resp", {wb_ack_o, wb_error_o, wb_data_o}, 0);
        check("midrst_irq", {irq_any, irq_o}, 0);
        wb_cyc = 1'b0; pb_busy = '0; irq_src = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_no_resp", resp_cnt - r0, 0);
        rd(24'hFF000C, 1'b0, 32'h0000_00FF, "midrst_timeout");

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/peripheral_bus_hub.md
Name: peripheral_bus_hub

Overview:
Parametrised successor to the fixed four-peripheral glue. Bridges a Wishbone slave port onto the shared peripheral bus for NUM_PERIPHERALS peripherals. Provides a registered access FSM with busy-wait, a timeout watchdog, unmapped and multi-hit detection, and a built-in interrupt controller with per-source pending, enable and edge/level mode. Sits between the core Wishbone fabric and the UART/SPI/PWM/GPIO peripheral instances.

Parameters:
NUM_PERIPHERALS, 4, number of peripheral read ports (1..16)
IRQ_COUNT, 10, number of interrupt sources (1..32)
IRQ_EDGE_MASK, all ones, per-source mode: bit=1 rising-edge, bit=0 level
HUB_ID, 8'hFF, wb_adr_i[23:16] value selecting the hub's own registers
TIMEOUT_DEFAULT, 16'd255, reset value of TIMEOUT register; 0 = watchdog off
ERR_ON_UNMAPPED, 1, 1 = unmapped read/write returns wb_error_o instead of wb_ack_o

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wb_cyc_i / wb_stb_i / wb_we_i  in  1 each  Wishbone control
wb_sel_i  in  4  byte select
wb_adr_i  in  24  byte address
wb_data_i  in  32  write data
wb_ack_o / wb_stall_o / wb_error_o  out  1 each  Wishbone response
wb_data_o  out  32  read data
pb_we / pb_oe  out  1 each  peripheral bus write/read strobe
pb_address  out  24  latched address
pb_byteSelect  out  4  latched byte select
pb_dataWrite  out  32  latched write data
pb_busy  in  NUM_PERIPHERALS  per-peripheral busy
pb_requestOutput  in  NUM_PERIPHERALS  per-peripheral claim
pb_dataRead  in  32*NUM_PERIPHERALS  flattened read data, peripheral i at [32i+31:32i]
irq_src  in  IRQ_COUNT  raw interrupt sources
irq_o  out  IRQ_COUNT  pending & enable
irq_any  out  1  OR of irq_o

Behaviour:
- Reset values: all outputs 0; pending 0; enable 0; ERR_STATUS 0; TIMEOUT = TIMEOUT_DEFAULT.
- wb_stall_o = (state != IDLE), combinational from state.
- FSM IDLE: on cyc&stb, latch adr/sel/data/we and go to ACCESS. Hub-ID addresses go to HUB instead.
- FSM ACCESS: pb_we or pb_oe = 1 every cycle.
  - If cyc drops: return to IDLE, no response.
  - Else, when |pb_busy == 0: capture the read mux output and claim flags, go to RESPOND.
  - Else, if TIMEOUT != 0 and wait counter == TIMEOUT: go to RESPOND with error, cause = timeout.
- FSM HUB: one cycle of internal register access, then RESPOND.
- FSM RESPOND: exactly one cycle of wb_ack_o (or wb_error_o), with wb_data_o valid, then IDLE.
- Minimum latency: ack 2 cycles after the accepting edge. Wait counter is 16 bits, cleared on ACCESS entry, saturates.
- Read mux: lowest-index asserted pb_requestOutput wins.
  - More than one claim: data from lowest index, ERR_STATUS.multi set, access still acks.
  - No claim: data = 32'hFFFFFFFF; error if ERR_ON_UNMAPPED, else ack. Writes apply the same unmapped rule.
- wb_data_o = 0 on writes and errors.
- Hub registers at offset adr[7:0]; other offsets read 0, writes ignored, ack:
  - 0x00 PENDING: read; write-1-to-clear.
  - 0x04 ENABLE: read/write.
  - 0x08 ERR_STATUS: [0] timeout, [1] unmapped, [2] multi, [31:8] last error address[23:0]; any write clears it.
  - 0x0C TIMEOUT: read/write, [15:0].
  - wb_sel_i applies per byte on all writes.
- Pending logic:
  - Edge source: set on 0→1 of the registered irq_src.
  - Level source: set while high; a clear re-sets the next cycle if still high.
  - Simultaneous set and W1C clear: set wins.
  - irq_o is registered.
- Reset asserted mid-transaction: FSM returns to IDLE, strobes drop, no ack is issued.

Decomposition:
- Package peripheral_bus_pkg holds:
  - FSM state enum {IDLE, ACCESS, HUB, RESPOND};
  - register offset constants;
  - ERR_STATUS bit indices;
  - PB_UNMAPPED_DATA = 32'hFFFFFFFF.
- Sub-module peripheral_irq_ctrl (pending/enable/edge logic, IRQ_COUNT and IRQ_EDGE_MASK parameters). The FSM and read mux stay in the top.

Test Plan:
- Single read: peripheral 2 claims with data 32'hA5A5_0003, busy low → wb_ack_o exactly 2 cycles after acceptance, wb_data_o=32'hA5A5_0003, stall high for 2 cycles.
- Busy wait: peripheral 1 busy for 5 cycles on a write → pb_we held 6 cycles, pb_dataWrite stable, single ack.
- Timeout: TIMEOUT=10, busy stuck high → wb_error_o on wait count 10; ERR_STATUS reads 32'h00xxxx01 with the address in [31:8].
- Unmapped/multi-hit:
  - no claim, ERR_ON_UNMAPPED=1 → error, ERR_STATUS[1]=1;
  - peripherals 0 and 3 both claim → data of peripheral 0, ack, ERR_STATUS[2]=1.
- IRQ edge vs level: enable=3FF, pulse src[0], hold src[9] high → irq_o[0] and irq_o[9] set. W1C 0x201 → bit 0 clears and stays clear; bit 9 re-asserts next cycle. Clear on the same cycle as a new src[0] edge → bit 0 stays set.
- Abort/reset: drop wb_cyc_i during ACCESS → no ack, IDLE next cycle. Assert rst_n low mid-access → all outputs 0 immediately, TIMEOUT=255.
